// File: rtl/fetch_predict_if.sv
// Fetch <-> ID / I-memory signal bundle for fetch_predict.
// The master side is the fetch stage; the slave side is ID plus the I-memory.
interface fetch_predict_if;
  logic        FREEZE_IN;
  logic [31:0] Instr_Addr_OUT;
  logic [31:0] Instr_IN;
  logic [31:0] Instr_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic        Res_Branch_IN;
  logic        Res_Taken_IN;
  logic [31:0] Res_Target_IN;
  logic        Mispredict_OUT;
  logic [31:0] Branch_Count_OUT;
  logic [31:0] Mispredict_Count_OUT;

  modport master (
    input  FREEZE_IN, Instr_IN, Res_Branch_IN, Res_Taken_IN, Res_Target_IN,
    output Instr_Addr_OUT, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
           Mispredict_OUT, Branch_Count_OUT, Mispredict_Count_OUT
  );

  modport slave (
    output FREEZE_IN, Instr_IN, Res_Branch_IN, Res_Taken_IN, Res_Target_IN,
    input  Instr_Addr_OUT, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
           Mispredict_OUT, Branch_Count_OUT, Mispredict_Count_OUT
  );
endinterface

// File: rtl/fetch_predict.sv
// Fetch stage with a direct-mapped BTB (2-bit counters) for a single-delay-slot pipeline.
// Predicted-taken branches redirect after their delay slot; ID's resolution trains and repairs.
module fetch_predict #(
  parameter int          INDEX_BITS = 4,
  parameter logic [31:0] RESET_PC   = 32'h00400000
) (
  input logic           CLK,
  input logic           RESET,
  fetch_predict_if.master bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 32 - INDEX_BITS - 2;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } hist_t;

  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] instr_pc4_q;
  logic        mispredict_q;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  logic              btb_valid  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [ENTRIES];
  logic [31:0]       btb_target [ENTRIES];
  logic [1:0]        btb_ctr    [ENTRIES];

  logic        pending_valid;
  logic [31:0] pending_target;
  hist_t       stage1;
  hist_t       stage2;

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_W-1:0]      lookup_tag;
  logic                  lookup_hit;
  logic                  predict_taken;
  logic [31:0]           predict_target;
  logic [INDEX_BITS-1:0] update_idx;
  logic [TAG_W-1:0]      update_tag;
  logic                  update_hit;
  logic                  resolve;
  logic                  mispredict;
  logic [31:0]           correct_pc;
  logic [31:0]           pc_plus4;
  logic [31:0]           next_pc;

  // A lookup in the delay slot of an already-predicted branch is ignored.
  always_comb begin
    lookup_idx     = pc[INDEX_BITS+1:2];
    lookup_tag     = pc[31:INDEX_BITS+2];
    lookup_hit     = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag);
    predict_taken  = lookup_hit && btb_ctr[lookup_idx][1] && !pending_valid;
    predict_target = btb_target[lookup_idx];
  end

  always_comb begin
    resolve    = bus.Res_Branch_IN && !bus.FREEZE_IN;
    correct_pc = bus.Res_Taken_IN ? bus.Res_Target_IN : stage2.pc + 32'd8;
    mispredict = resolve &&
                 ((bus.Res_Taken_IN != stage2.pred_taken) ||
                  (bus.Res_Taken_IN && (bus.Res_Target_IN != stage2.pred_target)));
    update_idx = stage2.pc[INDEX_BITS+1:2];
    update_tag = stage2.pc[31:INDEX_BITS+2];
    update_hit = btb_valid[update_idx] && (btb_tag[update_idx] == update_tag);
    pc_plus4   = pc + 32'd4;
    if (mispredict)
      next_pc = correct_pc;
    else if (pending_valid)
      next_pc = pending_target;
    else
      next_pc = pc_plus4;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc               <= RESET_PC;
      instr_q          <= 32'd0;
      instr_pc_q       <= 32'd0;
      instr_pc4_q      <= 32'd0;
      mispredict_q     <= 1'b0;
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
      pending_valid    <= 1'b0;
      pending_target   <= 32'd0;
      stage1           <= '0;
      stage2           <= '0;
    end else if (bus.FREEZE_IN) begin
      mispredict_q <= 1'b0;
    end else begin
      pc           <= next_pc;
      instr_q      <= mispredict ? 32'd0 : bus.Instr_IN;
      instr_pc_q   <= pc;
      instr_pc4_q  <= pc_plus4;
      mispredict_q <= mispredict;
      stage2       <= stage1;
      if (resolve)
        branch_count <= branch_count + 32'd1;
      if (mispredict) begin
        mispredict_count <= mispredict_count + 32'd1;
        pending_valid    <= 1'b0;
        stage1           <= '0;
      end else begin
        stage1 <= '{pc: pc, pred_taken: predict_taken, pred_target: predict_target};
        if (pending_valid) begin
          pending_valid <= 1'b0;
        end else if (predict_taken) begin
          pending_valid  <= 1'b1;
          pending_target <= predict_target;
        end
      end
    end
  end

  // Training uses the branch now in history stage 2, independent of this cycle's lookup.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= 32'd0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (resolve) begin
      if (update_hit) begin
        if (bus.Res_Taken_IN) begin
          btb_ctr[update_idx]    <= (btb_ctr[update_idx] == 2'b11) ? 2'b11 : btb_ctr[update_idx] + 2'd1;
          btb_target[update_idx] <= bus.Res_Target_IN;
        end else begin
          btb_ctr[update_idx] <= (btb_ctr[update_idx] == 2'b00) ? 2'b00 : btb_ctr[update_idx] - 2'd1;
        end
      end else if (bus.Res_Taken_IN) begin
        btb_valid[update_idx]  <= 1'b1;
        btb_tag[update_idx]    <= update_tag;
        btb_target[update_idx] <= bus.Res_Target_IN;
        btb_ctr[update_idx]    <= 2'b10;
      end
    end
  end

  assign bus.Instr_Addr_OUT       = pc;
  assign bus.Instr_OUT            = instr_q;
  assign bus.Instr_PC_OUT         = instr_pc_q;
  assign bus.Instr_PC_Plus4_OUT   = instr_pc4_q;
  assign bus.Mispredict_OUT       = mispredict_q;
  assign bus.Branch_Count_OUT     = branch_count;
  assign bus.Mispredict_Count_OUT = mispredict_count;
endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: a table of per-cycle ID resolutions with hand-derived
// fetch addresses and counters, plus hand-written reset sequences.
module tb_fetch_predict;
  localparam logic [31:0] BASE = 32'h00400000;

  typedef struct {
    bit          fr;
    bit          br;
    bit          tk;
    logic [31:0] tgt;
    logic [31:0] epc;
    logic [31:0] eipc;
    bit          esq;
    bit          emp;
    int          ebc;
    int          emc;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  fetch_predict_if bus ();

  fetch_predict #(.INDEX_BITS(4), .RESET_PC(BASE)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  // I-memory stand-in: a fixed scramble of the address so every fetch is distinguishable.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  assign bus.Instr_IN = imem(bus.Instr_Addr_OUT);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input bit fr, input bit br, input bit tk, input logic [31:0] tgt_off,
                              input logic [31:0] epc_off, input logic [31:0] eipc_off,
                              input bit esq, input bit emp, input int ebc, input int emc);
    vec_t v;
    v.fr   = fr;
    v.br   = br;
    v.tk   = tk;
    v.tgt  = BASE + tgt_off;
    v.epc  = BASE + epc_off;
    v.eipc = BASE + eipc_off;
    v.esq  = esq;
    v.emp  = emp;
    v.ebc  = ebc;
    v.emc  = emc;
    return v;
  endfunction

  task automatic applyStimulus(input bit fr, input bit br, input bit tk, input logic [31:0] tgt);
    bus.FREEZE_IN     = fr;
    bus.Res_Branch_IN = br;
    bus.Res_Taken_IN  = tk;
    bus.Res_Target_IN = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkRow(input string tag, input logic [31:0] epc, input logic [31:0] eipc,
                          input bit esq, input bit emp, input int ebc, input int emc);
    checkOutput({tag, " addr"}, bus.Instr_Addr_OUT, epc);
    checkOutput({tag, " instr"}, bus.Instr_OUT, esq ? 32'd0 : imem(eipc));
    checkOutput({tag, " instr_pc"}, bus.Instr_PC_OUT, eipc);
    checkOutput({tag, " instr_pc4"}, bus.Instr_PC_Plus4_OUT, eipc + 32'd4);
    checkOutput({tag, " mispredict"}, {31'd0, bus.Mispredict_OUT}, {31'd0, emp});
    checkOutput({tag, " branch_count"}, bus.Branch_Count_OUT, ebc);
    checkOutput({tag, " mispredict_count"}, bus.Mispredict_Count_OUT, emc);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Cold not-taken at 0x10, then a taken branch at 0x1C loops back to 0x10.
    vecs.push_back(mk(0,0,0,'h000, 'h008,'h004, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,'h000, 'h00C,'h008, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,'h000, 'h010,'h00C, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,'h000, 'h014,'h010, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,'h000, 'h018,'h014, 0,0, 0,0));
    vecs.push_back(mk(0,1,0,'h000, 'h01C,'h018, 0,0, 1,0));
    vecs.push_back(mk(0,0,0,'h000, 'h020,'h01C, 0,0, 1,0));
    vecs.push_back(mk(0,0,0,'h000, 'h024,'h020, 0,0, 1,0));
    vecs.push_back(mk(0,1,1,'h010, 'h010,'h024, 1,1, 2,1));
    // Refetch of 0x10 stays sequential; cold taken to 0x100 mispredicts at 0x18.
    vecs.push_back(mk(0,0,0,'h000, 'h014,'h010, 0,0, 2,1));
    vecs.push_back(mk(0,0,0,'h000, 'h018,'h014, 0,0, 2,1));
    vecs.push_back(mk(0,1,1,'h100, 'h100,'h018, 1,1, 3,2));
    vecs.push_back(mk(0,0,0,'h000, 'h104,'h100, 0,0, 3,2));
    vecs.push_back(mk(0,0,0,'h000, 'h108,'h104, 0,0, 3,2));
    vecs.push_back(mk(0,1,1,'h010, 'h010,'h108, 1,1, 4,3));
    // Predicted loop 0x10 -> 0x14 -> 0x100 -> 0x104 -> 0x10 with no mispredicts.
    vecs.push_back(mk(0,0,0,'h000, 'h014,'h010, 0,0, 4,3));
    vecs.push_back(mk(0,0,0,'h000, 'h100,'h014, 0,0, 4,3));
    vecs.push_back(mk(0,1,1,'h100, 'h104,'h100, 0,0, 5,3));
    vecs.push_back(mk(0,0,0,'h000, 'h010,'h104, 0,0, 5,3));
    vecs.push_back(mk(0,1,1,'h010, 'h014,'h010, 0,0, 6,3));
    vecs.push_back(mk(0,0,0,'h000, 'h100,'h014, 0,0, 6,3));
    // Trained 0x10 resolves not-taken: redirect to 0x18 overrides the hit at 0x100.
    vecs.push_back(mk(0,1,0,'h000, 'h018,'h100, 1,1, 7,4));
    vecs.push_back(mk(0,0,0,'h000, 'h01C,'h018, 0,0, 7,4));
    vecs.push_back(mk(0,0,0,'h000, 'h020,'h01C, 0,0, 7,4));
    vecs.push_back(mk(0,0,0,'h000, 'h010,'h020, 0,0, 7,4));
    vecs.push_back(mk(0,1,1,'h010, 'h014,'h010, 0,0, 8,4));
    vecs.push_back(mk(0,0,0,'h000, 'h100,'h014, 0,0, 8,4));
    vecs.push_back(mk(0,1,1,'h100, 'h104,'h100, 0,0, 9,4));
    vecs.push_back(mk(0,0,0,'h000, 'h010,'h104, 0,0, 9,4));
    // Target mismatch on 0x100 sends fetch to the alias 0x50 of index 4.
    vecs.push_back(mk(0,1,1,'h050, 'h050,'h010, 1,1, 10,5));
    vecs.push_back(mk(0,0,0,'h000, 'h054,'h050, 0,0, 10,5));
    vecs.push_back(mk(0,0,0,'h000, 'h058,'h054, 0,0, 10,5));
    vecs.push_back(mk(0,1,1,'h200, 'h200,'h058, 1,1, 11,6));
    vecs.push_back(mk(0,0,0,'h000, 'h204,'h200, 0,0, 11,6));
    vecs.push_back(mk(0,0,0,'h000, 'h208,'h204, 0,0, 11,6));
    vecs.push_back(mk(0,1,1,'h050, 'h050,'h208, 1,1, 12,7));
    vecs.push_back(mk(0,0,0,'h000, 'h054,'h050, 0,0, 12,7));
    vecs.push_back(mk(0,0,0,'h000, 'h200,'h054, 0,0, 12,7));
    // Freeze with a would-be mispredicting resolution, then the real one.
    vecs.push_back(mk(1,1,1,'h300, 'h200,'h054, 0,0, 12,7));
    vecs.push_back(mk(1,1,1,'h300, 'h200,'h054, 0,0, 12,7));
    vecs.push_back(mk(1,1,1,'h300, 'h200,'h054, 0,0, 12,7));
    vecs.push_back(mk(0,1,1,'h200, 'h204,'h200, 0,0, 13,7));
    vecs.push_back(mk(0,0,0,'h000, 'h050,'h204, 0,0, 13,7));

    reset = 1'b1;
    bus.FREEZE_IN     = 1'b0;
    bus.Res_Branch_IN = 1'b0;
    bus.Res_Taken_IN  = 1'b0;
    bus.Res_Target_IN = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset addr", bus.Instr_Addr_OUT, BASE);
    checkOutput("reset instr", bus.Instr_OUT, 32'd0);
    checkOutput("reset instr_pc", bus.Instr_PC_OUT, 32'd0);
    checkOutput("reset instr_pc4", bus.Instr_PC_Plus4_OUT, 32'd0);
    checkOutput("reset mispredict", {31'd0, bus.Mispredict_OUT}, 32'd0);
    checkOutput("reset branch_count", bus.Branch_Count_OUT, 32'd0);
    checkOutput("reset mispredict_count", bus.Mispredict_Count_OUT, 32'd0);

    reset = 1'b0;
    applyStimulus(0, 0, 0, 32'd0);
    checkRow("release", BASE + 32'h4, BASE, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fr, vecs[i].br, vecs[i].tk, vecs[i].tgt);
      checkRow($sformatf("row%0d", i), vecs[i].epc, vecs[i].eipc, vecs[i].esq, vecs[i].emp,
               vecs[i].ebc, vecs[i].emc);
    end

    // Reset while a predicted redirect is pending: everything, including the BTB, is discarded.
    reset = 1'b1;
    applyStimulus(0, 0, 0, 32'd0);
    checkOutput("midreset addr", bus.Instr_Addr_OUT, BASE);
    checkOutput("midreset instr", bus.Instr_OUT, 32'd0);
    checkOutput("midreset branch_count", bus.Branch_Count_OUT, 32'd0);
    checkOutput("midreset mispredict_count", bus.Mispredict_Count_OUT, 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, 0, 32'd0);
      checkOutput($sformatf("postreset addr%0d", k), bus.Instr_Addr_OUT, BASE + 32'(4 * k));
      checkOutput($sformatf("postreset instr%0d", k), bus.Instr_OUT, imem(BASE + 32'(4 * (k - 1))));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_predict.md
Name: fetch_predict

Overview:
- Fetch stage directly upstream of ID. Owns the PC and drives the I-memory address.
- Registers the fetched instruction, PC and PC+4 into ID.
- Predicts branch/jump direction and target from a direct-mapped BTB with 2-bit counters.
- Consumes ID's registered branch resolution to train the BTB, detect mispredicts, redirect fetch and squash one wrong-path instruction.

Parameters:
- INDEX_BITS, 4, BTB index width; BTB has 2^INDEX_BITS entries, indexed by PC[INDEX_BITS+1:2].
- RESET_PC, 32'h00400000, first fetch address after reset.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- FREEZE_IN  in  1  from ID WANT_FREEZE; hold all state
- Instr_Addr_OUT  out  32  current fetch PC to I-memory (equals PC register)
- Instr_IN  in  32  I-memory data for Instr_Addr_OUT, same cycle
- Instr_OUT  out  32  registered instruction to ID
- Instr_PC_OUT  out  32  registered PC to ID
- Instr_PC_Plus4_OUT  out  32  registered PC+4 to ID
- Res_Branch_IN  in  1  ID registered is_branch (instr ID held last cycle)
- Res_Taken_IN  in  1  ID Request_Alt_PC
- Res_Target_IN  in  32  ID Alt_PC
- Mispredict_OUT  out  1  registered pulse: redirect occurred this edge
- Branch_Count_OUT  out  32  resolved branches (wraps)
- Mispredict_Count_OUT  out  32  mispredicts (wraps)

Behaviour:
- Reset (sync, RESET=1 at posedge):
  - PC=RESET_PC.
  - Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Mispredict_OUT, both counters = 0.
  - All BTB valid bits=0, counters=2'b01; pending and history cleared.
  - Reset mid-redirect discards everything.
- BTB entry: valid, tag=PC[31:INDEX_BITS+2], target[31:0], ctr[1:0]. Predict taken iff valid && tag match && ctr>=2.
- Delay-slot timing:
  - t: branch at p fetched; lookup. If predicted taken, set pending={target}.
  - t+1: fetch p+4 (delay slot); next PC = pending target if set, else p+8 via normal +4.
  - t+2: fetch predicted path; Res_* describes the branch.
- History: 2-stage shift {pc, pred_taken, pred_target}, advanced each unfrozen cycle. Stage 2 is the instruction Res_* describes.
- Lookup while pending is set (branch in delay slot) is ignored; no prediction.
- Resolution, when Res_Branch_IN && !FREEZE_IN, against stage-2 entry:
  - correct = Res_Taken_IN ? Res_Target_IN : stage2.pc+8.
  - Mispredict iff Res_Taken_IN != pred_taken, or taken with Res_Target_IN != pred_target.
  - On mispredict:
    - PC<=correct.
    - Instr_OUT<=0 (NOP squash of the wrong-path fetch this cycle); PC outputs still load.
    - Clear pending and history stage 1.
    - Mispredict_OUT<=1; Mispredict_Count_OUT+1.
  - Branch_Count_OUT+1 on every resolution.
- BTB update (same edge):
  - Hit: taken -> saturating increment, target<=Res_Target_IN; not taken -> saturating decrement.
  - Miss and taken: allocate valid, tag, target, ctr=2'b10.
  - Miss and not taken: no allocate.
- Mispredict has priority over a same-cycle lookup hit; that lookup result is dropped.
- FREEZE_IN=1:
  - PC, outputs, history, pending, BTB and counters hold; resolution ignored.
  - Mispredict_OUT<=0.
- Otherwise Mispredict_OUT<=0. PC+4 arithmetic is 32-bit, wraps.

Test Plan:
- Reset: RESET=1 two cycles, release -> Instr_Addr_OUT=32'h00400000; all outputs 0; next cycle 32'h00400004.
- Cold not-taken branch at 0x00400010, Res_Taken_IN=0 -> no redirect, Mispredict_OUT=0, Branch_Count_OUT=1, no BTB allocate (refetch still sequential).
- Cold taken branch at 0x00400010, target 0x00400100:
  - Fetch at t+2 is 0x00400018; Res_Taken_IN=1 -> Instr_OUT=0, next PC=0x00400100, Mispredict_OUT=1, Mispredict_Count_OUT=1.
  - Loop back to the same branch: fetches 0x00400010, 0x00400014, 0x00400100 with no mispredict.
- Trained entry (ctr=3), then Res_Taken_IN=0 -> redirect to 0x00400018, ctr=2; next encounter still predicts taken.
- Aliasing: taken branch 0x00400010 trained, then branch 0x00400050 (same index, different tag) -> no prediction; taken resolution replaces entry.
- FREEZE_IN=1 for 3 cycles with Res_Branch_IN=1 -> PC and outputs unchanged, counters unchanged; resolves normally after release.
